// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/ack bus and decode handshake.
// The master modport is the fetch stage; the slave modport is memory, decode and the branch unit.
interface if_fetch_stage_if #(
  parameter int WIDTH = 32
);
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             id_valid;
  logic             id_ready;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_instr;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_pc, id_instr
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, registered output slot plus one skid entry,
// and a DROP state that discards the in-flight response after a redirect.
module if_fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_stage_if.master bus
);

  typedef enum logic {RUN, DROP} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] drop_addr;
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_instr;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_pc;
  logic [WIDTH-1:0] skid_instr;

  logic             req;
  logic             ack;
  logic             slot_free;
  logic [WIDTH-1:0] target;
  logic             unused_lo;

  // A full skid entry implies the output slot is also full, so no new request is issued.
  assign req       = (state == DROP) | ((state == RUN) & !skid_valid);
  assign ack       = req & bus.imem_ack;
  assign slot_free = !id_valid | bus.id_ready;
  assign target    = {bus.redirect_pc[WIDTH-1:2], 2'b00};
  assign unused_lo = ^bus.redirect_pc[1:0];

  assign bus.imem_req  = req;
  assign bus.imem_addr = (state == DROP) ? drop_addr : pc;
  assign bus.id_valid  = id_valid;
  assign bus.id_pc     = id_pc;
  assign bus.id_instr  = id_instr;

  // NOTE: all state is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order in this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      drop_addr  <= '0;
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (bus.redirect) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
      pc         <= target;
      // A request still in flight must be held on the bus and its response thrown away.
      if (state == RUN && req && !bus.imem_ack) begin
        drop_addr <= pc;
        state     <= DROP;
      end else if (state == DROP && bus.imem_ack) begin
        state <= RUN;
      end
    end else if (state == DROP) begin
      if (bus.imem_ack) state <= RUN;
    end else begin
      if (slot_free) begin
        if (skid_valid) begin
          id_valid   <= 1'b1;
          id_pc      <= skid_pc;
          id_instr   <= skid_instr;
          skid_valid <= 1'b0;
        end else if (ack) begin
          id_valid <= 1'b1;
          id_pc    <= pc;
          id_instr <= bus.imem_rdata;
        end else begin
          id_valid <= 1'b0;
        end
      end else if (ack) begin
        skid_valid <= 1'b1;
        skid_pc    <= pc;
        skid_instr <= bus.imem_rdata;
      end
      if (ack) pc <= pc + WIDTH'(4);
    end
  end

endmodule
